// File: rtl/isa_pkg.sv
// Shared definitions for the ISA streaming path: instruction header layout and FSM states.
package isa_pkg;

  localparam int unsigned OPCODE_WIDTH  = 8;
  localparam int unsigned NUMWORD_WIDTH = 8;
  localparam int unsigned OPCODE_LSB    = 0;
  localparam int unsigned NUMWORD_LSB   = 8;

  typedef enum logic [1:0] {IDLE, RUN, FIN} isaStateE;

  // Words that follow a header; a zero count is treated as a one-word instruction.
  function automatic logic [NUMWORD_WIDTH-1:0] wordsAfterHdr(
    input logic [NUMWORD_WIDTH-1:0] cnt
  );
    return (cnt == '0) ? '0 : cnt - NUMWORD_WIDTH'(1);
  endfunction

endpackage

// File: rtl/isa_prefetch_fifo.sv
// First-word-fall-through prefetch buffer between the global-buffer read port and the CCU stream.
module isa_prefetch_fifo #(
  parameter int unsigned PORT_WIDTH    = 128,
  parameter int unsigned PF_ADDR_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [PORT_WIDTH-1:0]   pushDat,
  input  logic                    pop,
  output logic [PORT_WIDTH-1:0]   headDat,
  output logic [PF_ADDR_WIDTH:0]  count,
  output logic                    empty
);

  localparam int unsigned DEPTH = 2 ** PF_ADDR_WIDTH;

  logic [PORT_WIDTH-1:0]    mem [DEPTH];
  logic [PF_ADDR_WIDTH-1:0] wrPtrQ, rdPtrQ;
  logic [PF_ADDR_WIDTH:0]   cntQ;

  // Storage is cleared on reset so the head presented to the CCU reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '{default: '0};
    end else if (push) begin
      mem[wrPtrQ] <= pushDat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      cntQ   <= '0;
    end else begin
      if (push) begin
        wrPtrQ <= wrPtrQ + PF_ADDR_WIDTH'(1);
      end
      if (pop) begin
        rdPtrQ <= rdPtrQ + PF_ADDR_WIDTH'(1);
      end
      unique case ({push, pop})
        2'b10:   cntQ <= cntQ + (PF_ADDR_WIDTH + 1)'(1);
        2'b01:   cntQ <= cntQ - (PF_ADDR_WIDTH + 1)'(1);
        default: cntQ <= cntQ;
      endcase
    end
  end

  assign headDat = mem[rdPtrQ];
  assign count   = cntQ;
  assign empty   = (cntQ == '0);

endmodule

// File: rtl/isa_streamer.sv
// Streams a run of ISA words from the global buffer to the CCU, tracking instruction headers.
// Optional header gating on per-target CfgRdy is enabled by defining ISA_CFGRDY_GATE_EN.
module isa_streamer
  import isa_pkg::*;
#(
  parameter int unsigned PORT_WIDTH     = 128,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned NUM_WORD_WIDTH = 16,
  parameter int unsigned OPNUM          = 6,
  parameter int unsigned PF_ADDR_WIDTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      Start,
  input  logic [ADDR_WIDTH-1:0]     BaseAddr,
  input  logic [NUM_WORD_WIDTH-1:0] NumWord,
  output logic                      Busy,
  output logic                      Done,
  output logic [15:0]               InstrCnt,
  output logic [ADDR_WIDTH-1:0]     ITFGLB_RdAddr,
  output logic                      ITFGLB_RdAddrVld,
  input  logic                      GLBITF_RdAddrRdy,
  input  logic [PORT_WIDTH-1:0]     GLBITF_RdDat,
  input  logic                      GLBITF_RdDatVld,
  output logic [PORT_WIDTH-1:0]     ITFCCU_ISARdDat,
  output logic                      ITFCCU_ISARdDatVld,
  input  logic                      CCUITF_ISARdDatRdy,
  input  logic [OPNUM-1:0]          CCUITF_CfgRdy
);

  localparam int unsigned DEPTH = 2 ** PF_ADDR_WIDTH;
  localparam int unsigned CW    = PF_ADDR_WIDTH + 2;

  isaStateE                  stateQ, stateD;
  logic [ADDR_WIDTH-1:0]     addrQ;
  logic [NUM_WORD_WIDTH-1:0] reqLeftQ, outLeftQ;
  logic [PF_ADDR_WIDTH:0]    outstandingQ;
  logic [NUMWORD_WIDTH-1:0]  wordLeftQ;
  logic [15:0]               instrCntQ;

  logic                      accept, addrHs, isaHs, lastHs, creditOk;
  logic                      fifoEmpty, hold, isHeader;
  logic [PF_ADDR_WIDTH:0]    fifoCnt;
  logic [CW-1:0]             inFlight;
  logic [PORT_WIDTH-1:0]     headDat;
  logic [OPCODE_WIDTH-1:0]   opcode;
  logic [NUMWORD_WIDTH-1:0]  hdrCnt;

  assign accept   = (stateQ == IDLE) && Start;
  assign addrHs   = ITFGLB_RdAddrVld && GLBITF_RdAddrRdy;
  assign isaHs    = ITFCCU_ISARdDatVld && CCUITF_ISARdDatRdy;
  assign lastHs   = isaHs && (outLeftQ == NUM_WORD_WIDTH'(1));
  // Buffered plus still-in-flight words never exceed the FIFO depth, so it cannot overflow.
  assign inFlight = CW'(fifoCnt) + CW'(outstandingQ);
  assign creditOk = inFlight < CW'(DEPTH);

  assign isHeader = (wordLeftQ == '0);
  assign opcode   = headDat[OPCODE_LSB +: OPCODE_WIDTH];
  assign hdrCnt   = headDat[NUMWORD_LSB +: NUMWORD_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE: begin
        if (Start) begin
          stateD = (NumWord != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        if (lastHs) begin
          stateD = FIN;
        end
      end
      FIN:     stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    Busy             = (stateQ != IDLE);
    Done             = (stateQ == FIN);
    ITFGLB_RdAddrVld = (stateQ == RUN) && (reqLeftQ != '0) && creditOk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrQ     <= '0;
      reqLeftQ  <= '0;
      outLeftQ  <= '0;
      wordLeftQ <= '0;
      instrCntQ <= '0;
    end else if (accept) begin
      addrQ     <= BaseAddr;
      reqLeftQ  <= NumWord;
      outLeftQ  <= NumWord;
      wordLeftQ <= '0;
      instrCntQ <= '0;
    end else begin
      if (addrHs) begin
        addrQ    <= addrQ + ADDR_WIDTH'(1);
        reqLeftQ <= reqLeftQ - NUM_WORD_WIDTH'(1);
      end
      if (isaHs) begin
        outLeftQ <= outLeftQ - NUM_WORD_WIDTH'(1);
        if (isHeader) begin
          wordLeftQ <= wordsAfterHdr(hdrCnt);
          if (instrCntQ != 16'hFFFF) begin
            instrCntQ <= instrCntQ + 16'd1;
          end
        end else begin
          wordLeftQ <= wordLeftQ - NUMWORD_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstandingQ <= '0;
    end else begin
      unique case ({addrHs, GLBITF_RdDatVld})
        2'b10:   outstandingQ <= outstandingQ + (PF_ADDR_WIDTH + 1)'(1);
        2'b01:   outstandingQ <= outstandingQ - (PF_ADDR_WIDTH + 1)'(1);
        default: outstandingQ <= outstandingQ;
      endcase
    end
  end

  isa_prefetch_fifo #(
    .PORT_WIDTH    (PORT_WIDTH),
    .PF_ADDR_WIDTH (PF_ADDR_WIDTH)
  ) u_prefetch (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (GLBITF_RdDatVld),
    .pushDat (GLBITF_RdDat),
    .pop     (isaHs),
    .headDat (headDat),
    .count   (fifoCnt),
    .empty   (fifoEmpty)
  );

`ifdef ISA_CFGRDY_GATE_EN
  logic gatedOp, cfgRdySel, vldShownQ;

  always_comb begin
    gatedOp   = 1'b0;
    cfgRdySel = 1'b0;
    for (int unsigned i = 0; i < OPNUM; i++) begin
      if (opcode == OPCODE_WIDTH'(i)) begin
        gatedOp   = 1'b1;
        cfgRdySel = CCUITF_CfgRdy[i];
      end
    end
  end

  // Once a header has been offered it stays offered until taken, whatever CfgRdy does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vldShownQ <= 1'b0;
    end else if (isaHs) begin
      vldShownQ <= 1'b0;
    end else if (ITFCCU_ISARdDatVld) begin
      vldShownQ <= 1'b1;
    end
  end

  assign hold = isHeader && gatedOp && !cfgRdySel && !vldShownQ;
`else
  logic unusedCfgRdy;
  logic [OPCODE_WIDTH-1:0] unusedOpcode;
  assign unusedCfgRdy = ^CCUITF_CfgRdy;
  assign unusedOpcode = opcode;
  assign hold         = 1'b0;
`endif

  assign ITFCCU_ISARdDatVld = !fifoEmpty && !hold;
  assign ITFCCU_ISARdDat    = headDat;
  assign ITFGLB_RdAddr      = addrQ;
  assign InstrCnt           = instrCntQ;

endmodule

// File: tb/tb_isa_streamer.sv
// Directed bench for isa_streamer: a two-cycle-latency global-buffer model plus per-scenario tasks.
module tb_isa_streamer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          Start;
  logic [15:0]   BaseAddr;
  logic [15:0]   NumWord;
  logic          Busy, Done;
  logic [15:0]   InstrCnt;
  logic [15:0]   ITFGLB_RdAddr;
  logic          ITFGLB_RdAddrVld;
  logic          GLBITF_RdAddrRdy;
  logic [127:0]  GLBITF_RdDat;
  logic          GLBITF_RdDatVld;
  logic [127:0]  ITFCCU_ISARdDat;
  logic          ITFCCU_ISARdDatVld;
  logic          CCUITF_ISARdDatRdy;
  logic [5:0]    CCUITF_CfgRdy;

  int checks = 0;
  int errors = 0;

  logic [127:0] glbMem [256];
  logic [15:0]  addrLog [$];
  logic [127:0] datLog [$];
  time          lastHsTime;
  logic [128:0] glbStage0, glbStage1;

  always #5 clk = ~clk;

  isa_streamer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .Start              (Start),
    .BaseAddr           (BaseAddr),
    .NumWord            (NumWord),
    .Busy               (Busy),
    .Done               (Done),
    .InstrCnt           (InstrCnt),
    .ITFGLB_RdAddr      (ITFGLB_RdAddr),
    .ITFGLB_RdAddrVld   (ITFGLB_RdAddrVld),
    .GLBITF_RdAddrRdy   (GLBITF_RdAddrRdy),
    .GLBITF_RdDat       (GLBITF_RdDat),
    .GLBITF_RdDatVld    (GLBITF_RdDatVld),
    .ITFCCU_ISARdDat    (ITFCCU_ISARdDat),
    .ITFCCU_ISARdDatVld (ITFCCU_ISARdDatVld),
    .CCUITF_ISARdDatRdy (CCUITF_ISARdDatRdy),
    .CCUITF_CfgRdy      (CCUITF_CfgRdy)
  );

  // Global buffer: address accepted at edge k returns data sampled at edge k+2.
  initial begin
    GLBITF_RdDatVld = 1'b0;
    GLBITF_RdDat    = '0;
    glbStage0       = '0;
    glbStage1       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        glbStage0 = '0;
        glbStage1 = '0;
        {GLBITF_RdDatVld, GLBITF_RdDat} = '0;
      end else begin
        {GLBITF_RdDatVld, GLBITF_RdDat} = glbStage1;
        glbStage1 = glbStage0;
        glbStage0 = (ITFGLB_RdAddrVld && GLBITF_RdAddrRdy) ?
                    {1'b1, glbMem[ITFGLB_RdAddr[7:0]]} : '0;
      end
    end
  end

  // Records every address and ISA handshake for the scenario tasks to inspect.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ITFGLB_RdAddrVld && GLBITF_RdAddrRdy) addrLog.push_back(ITFGLB_RdAddr);
        if (ITFCCU_ISARdDatVld && CCUITF_ISARdDatRdy) begin
          datLog.push_back(ITFCCU_ISARdDat);
          lastHsTime = $time;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [127:0] hdr(input logic [7:0] op, input logic [7:0] cnt,
                                       input logic [111:0] pay);
    return {pay, cnt, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic startRun(input logic [15:0] base, input logic [15:0] num);
    addrLog.delete();
    datLog.delete();
    Start    = 1'b1;
    BaseAddr = base;
    NumWord  = num;
    tick();
    Start    = 1'b0;
  endtask

  task automatic waitDone(input int maxCyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxCyc && !seen; i++) begin
      @(negedge clk);
      if (Done) seen = 1'b1;
    end
  endtask

  task automatic checkRun(input string name, input logic [15:0] base, input int n,
                          input logic [15:0] expInstr);
    logic [127:0] got;
    logic [15:0]  gotA;
    checks++;
    if (addrLog.size() !== n || datLog.size() !== n) begin
      errors++;
      $display("FAIL %s_count: got addr %0d data %0d required %0d", name, addrLog.size(),
               datLog.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      gotA = (i < addrLog.size()) ? addrLog[i] : 16'hxxxx;
      got  = (i < datLog.size()) ? datLog[i] : 'x;
      checks++;
      if (gotA !== 16'(base + 16'(i))) begin
        errors++;
        $display("FAIL %s_addr%0d: got %h required %h", name, i, gotA, 16'(base + 16'(i)));
      end
      checks++;
      if (got !== glbMem[8'(base + 16'(i))]) begin
        errors++;
        $display("FAIL %s_data%0d: got %h required %h", name, i, got,
                 glbMem[8'(base + 16'(i))]);
      end
    end
    checks++;
    if (InstrCnt !== expInstr) begin
      errors++;
      $display("FAIL %s_instrcnt: got %0d required %0d", name, InstrCnt, expInstr);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({Busy, Done, ITFGLB_RdAddrVld, ITFCCU_ISARdDatVld} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000",
               {Busy, Done, ITFGLB_RdAddrVld, ITFCCU_ISARdDatVld});
    end
    checks++;
    if (InstrCnt !== 16'd0 || ITFCCU_ISARdDat !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: got cnt %0d dat %h required 0", InstrCnt, ITFCCU_ISARdDat);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit seen;
    glbMem[8'h10] = hdr(8'd1, 8'd1, 112'hA1);
    glbMem[8'h11] = hdr(8'd2, 8'd2, 112'hB2);
    glbMem[8'h12] = {112'hC3, 16'hFF07};
    startRun(16'h0010, 16'd3);
    @(negedge clk);
    checks++;
    if (Busy !== 1'b1 || ITFGLB_RdAddrVld !== 1'b1) begin
      errors++;
      $display("FAIL basic_start: got busy %b rdvld %b required 1 1", Busy, ITFGLB_RdAddrVld);
    end
    waitDone(40, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL basic_done: got no Done required Done within 40 cycles");
    end
    checks++;
    if ($time - lastHsTime !== 64'd10) begin
      errors++;
      $display("FAIL basic_done_lat: got %0t after last HS required 10", $time - lastHsTime);
    end
    checkRun("basic", 16'h0010, 3, 16'd2);
    tick();
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got busy %b done %b required 0 0", Busy, Done);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit seen, vldSeen, stableOk;
    for (int i = 0; i < 8; i++) glbMem[8'h20 + 8'(i)] = hdr(8'd9, 8'd1, 112'(32'h5000 + i));
    CCUITF_ISARdDatRdy = 1'b0;
    startRun(16'h0020, 16'd8);
    vldSeen  = 1'b0;
    stableOk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ITFCCU_ISARdDatVld) begin
        vldSeen = 1'b1;
        if (ITFCCU_ISARdDat !== glbMem[8'h20]) stableOk = 1'b0;
      end
    end
    checks++;
    if (addrLog.size() !== 4) begin
      errors++;
      $display("FAIL bp_credit: got %0d reads issued required 4", addrLog.size());
    end
    checks++;
    if (!vldSeen || !stableOk) begin
      errors++;
      $display("FAIL bp_hold: got vld %b stable %b required 1 1", vldSeen, stableOk);
    end
    tick();
    CCUITF_ISARdDatRdy = 1'b1;
    waitDone(60, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_done: got no Done required Done within 60 cycles");
    end
    checkRun("bp", 16'h0020, 8, 16'd8);
    tick();
    tick();
  endtask

  task automatic test_empty_run();
    bit seen;
    startRun(16'h0000, 16'd0);
    @(negedge clk);
    checks++;
    if ({Done, Busy, ITFGLB_RdAddrVld} !== 3'b110) begin
      errors++;
      $display("FAIL empty_fin: got done/busy/rdvld %b required 110",
               {Done, Busy, ITFGLB_RdAddrVld});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({Done, Busy} !== 2'b00 || addrLog.size() !== 0) begin
      errors++;
      $display("FAIL empty_idle: got done/busy %b reads %0d required 00 0", {Done, Busy},
               addrLog.size());
    end
    tick();
    glbMem[8'h40] = hdr(8'd1, 8'd3, 112'h40);
    glbMem[8'h41] = {112'h41, 16'h0000};
    glbMem[8'h42] = {112'h42, 16'h0000};
    glbMem[8'h43] = hdr(8'd2, 8'd1, 112'h43);
    startRun(16'h0040, 16'd4);
    tick();
    Start    = 1'b1;
    BaseAddr = 16'h0080;
    NumWord  = 16'd1;
    tick();
    Start    = 1'b0;
    waitDone(40, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ignore_done: got no Done required Done within 40 cycles");
    end
    checkRun("ignore", 16'h0040, 4, 16'd2);
    repeat (4) tick();
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || addrLog.size() !== 4) begin
      errors++;
      $display("FAIL ignore_after: got busy %b reads %0d required 0 4", Busy, addrLog.size());
    end
    tick();
  endtask

  task automatic test_addr_wrap();
    bit seen;
    glbMem[8'hFF] = hdr(8'd5, 8'd0, 112'hFF);
    glbMem[8'h00] = hdr(8'd6, 8'd1, 112'h100);
    startRun(16'hFFFF, 16'd2);
    waitDone(40, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wrap_done: got no Done required Done within 40 cycles");
    end
    checkRun("wrap", 16'hFFFF, 2, 16'd2);
    tick();
    tick();
  endtask

  task automatic test_cfgrdy_gate();
    bit seen, vldSeen, expSeen;
`ifdef ISA_CFGRDY_GATE_EN
    expSeen = 1'b0;
`else
    expSeen = 1'b1;
`endif
    glbMem[8'h50] = hdr(8'd3, 8'd1, 112'h53);
    glbMem[8'h51] = hdr(8'd7, 8'd1, 112'h57);
    CCUITF_CfgRdy      = 6'b000000;
    CCUITF_ISARdDatRdy = 1'b0;
    startRun(16'h0050, 16'd2);
    vldSeen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ITFCCU_ISARdDatVld) vldSeen = 1'b1;
    end
    checks++;
    if (vldSeen !== expSeen) begin
      errors++;
      $display("FAIL gate_hold: got vld seen %b required %b", vldSeen, expSeen);
    end
    tick();
    CCUITF_CfgRdy = 6'b001000;
    @(negedge clk);
    checks++;
    if (ITFCCU_ISARdDatVld !== 1'b1 || ITFCCU_ISARdDat !== glbMem[8'h50]) begin
      errors++;
      $display("FAIL gate_release: got vld %b dat %h required 1 %h", ITFCCU_ISARdDatVld,
               ITFCCU_ISARdDat, glbMem[8'h50]);
    end
    tick();
    CCUITF_CfgRdy = 6'b000000;
    @(negedge clk);
    checks++;
    if (ITFCCU_ISARdDatVld !== 1'b1) begin
      errors++;
      $display("FAIL gate_sticky: got vld %b required 1", ITFCCU_ISARdDatVld);
    end
    tick();
    CCUITF_ISARdDatRdy = 1'b1;
    waitDone(40, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL gate_done: got no Done required Done within 40 cycles");
    end
    checkRun("gate", 16'h0050, 2, 16'd2);
    CCUITF_CfgRdy = 6'b111111;
    tick();
    tick();
  endtask

  task automatic test_reset_midrun();
    bit seen;
    for (int i = 0; i < 4; i++) glbMem[8'h60 + 8'(i)] = hdr(8'd8, 8'd1, 112'(32'h6000 + i));
    CCUITF_ISARdDatRdy = 1'b0;
    startRun(16'h0060, 16'd4);
    repeat (4) tick();
    checks++;
    if (ITFCCU_ISARdDatVld !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got vld %b required 1", ITFCCU_ISARdDatVld);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, ITFGLB_RdAddrVld, ITFCCU_ISARdDatVld} !== 4'b0 ||
        InstrCnt !== 16'd0 || ITFCCU_ISARdDat !== 128'd0) begin
      errors++;
      $display("FAIL rstmid_clear: got ctrl %b cnt %0d dat %h required 0",
               {Busy, Done, ITFGLB_RdAddrVld, ITFCCU_ISARdDatVld}, InstrCnt, ITFCCU_ISARdDat);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    CCUITF_ISARdDatRdy = 1'b1;
    glbMem[8'h70] = hdr(8'd4, 8'd2, 112'h70);
    glbMem[8'h71] = {112'h71, 16'h0303};
    startRun(16'h0070, 16'd2);
    waitDone(40, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rstmid_done: got no Done required Done within 40 cycles");
    end
    checkRun("rstmid", 16'h0070, 2, 16'd1);
    tick();
  endtask

  initial begin
    rst_n              = 1'b0;
    Start              = 1'b0;
    BaseAddr           = '0;
    NumWord            = '0;
    GLBITF_RdAddrRdy   = 1'b1;
    CCUITF_ISARdDatRdy = 1'b1;
    CCUITF_CfgRdy      = 6'b111111;
    lastHsTime         = 0;
    for (int i = 0; i < 256; i++) glbMem[i] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_run();
    test_addr_wrap();
    test_cfgrdy_gate();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
